// File: rtl/fetch_pc_fd_reg_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_fd_reg_if
//   Bundles the signals between the fetch stage and the rest of the core:
//   - next-PC logic
//   - hazard unit
//   - instruction memory
//   - decode stage
//
// Parameter
//   CNT_W        : width of the stall-cycle counter. It must match the
//                  fetch_pc_fd_reg instance that uses this interface.
//
// Signals (direction as seen from the fetch stage, the slave side)
//   stall        in   hazard-unit stall, freezes PC and F/D
//   fd_clear     in   bubble request, loads a nop into F/D
//   F_nextPC     in   next fetch address from the next-PC logic
//   i_inst_rdata in   instruction word for i_inst_addr (asynchronous IM)
//   F_PC         out  current fetch PC
//   i_inst_addr  out  IM address, equal to F_PC
//   D_instr      out  instruction held in D
//   D_PC         out  PC of D_instr
//   D_valid      out  D_instr is a fetched instruction, not a bubble
//   stall_cnt    out  saturating count of stalled cycles
//   fetch_err    out  illegal-fetch flag (0 unless address checking is built)
// -----------------------------------------------------------------------------
interface fetch_pc_fd_reg_if #(
   parameter int CNT_W = 16
);
   logic             stall;
   logic             fd_clear;
   logic [31:0]      F_nextPC;
   logic [31:0]      i_inst_rdata;
   logic [31:0]      F_PC;
   logic [31:0]      i_inst_addr;
   logic [31:0]      D_instr;
   logic [31:0]      D_PC;
   logic             D_valid;
   logic [CNT_W-1:0] stall_cnt;
   logic             fetch_err;

   // Core side: drives the controls, the next PC and the IM data.
   modport master (
      output stall, fd_clear, F_nextPC, i_inst_rdata,
      input  F_PC, i_inst_addr, D_instr, D_PC, D_valid, stall_cnt, fetch_err
   );

   // Fetch stage side.
   modport slave (
      input  stall, fd_clear, F_nextPC, i_inst_rdata,
      output F_PC, i_inst_addr, D_instr, D_PC, D_valid, stall_cnt, fetch_err
   );
endinterface

// File: rtl/fetch_pc_fd_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_fd_reg
//   This module holds the F-stage PC register and the F/D pipeline register
//   of the 5-stage MIPS core. It drives the instruction-memory address
//   combinationally from the PC. On each unstalled edge it latches the
//   returned word and its PC into D.
//
//   While the core is stalled, a saturating counter counts the stalled
//   cycles for performance debug.
//
// Parameters
//   PC_RESET : F_PC value after reset (text segment base)
//   CNT_W    : stall counter width
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   bus      slave modport of fetch_pc_fd_reg_if (see that file)
//
// Build option
//   FETCH_ADDR_CHECK_EN
//     When this macro is defined, a fetch from a misaligned PC or from a PC
//     outside 0x3000..0x6FFC is turned into a bubble, and fetch_err is set.
//     When it is not defined, fetch_err is tied to 0.
// -----------------------------------------------------------------------------
module fetch_pc_fd_reg #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   fetch_pc_fd_reg_if.slave  bus
);

   logic [31:0]      r_pc;
   logic [31:0]      r_d_instr;
   logic [31:0]      r_d_pc;
   logic             r_d_valid;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_fetch_illegal;

`ifdef FETCH_ADDR_CHECK_EN
   logic             r_fetch_err;

   // The check looks at the PC being fetched now, which is the word that
   // would be captured into D on this edge.
   assign w_fetch_illegal = (r_pc[1:0] != 2'b00) ||
                            (r_pc < 32'h0000_3000) ||
                            (r_pc > 32'h0000_6FFC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_err <= 1'b0;
      end else if (!bus.stall) begin
         // A cleared edge never reports an error, even if the PC is bad.
         r_fetch_err <= !bus.fd_clear && w_fetch_illegal;
      end
   end

   assign bus.fetch_err = r_fetch_err;
`else
   assign w_fetch_illegal = 1'b0;
   assign bus.fetch_err   = 1'b0;
`endif

   // PC and F/D register. Stall wins over clear, and clear wins over a
   // normal load. D_PC follows F_PC even for bubbles, so that a later
   // exception still has a PC to report.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc      <= PC_RESET;
         r_d_instr <= 32'h0;
         r_d_pc    <= 32'h0;
         r_d_valid <= 1'b0;
      end else if (!bus.stall) begin
         // The next PC is stored exactly as given, including bits [1:0].
         r_pc   <= bus.F_nextPC;
         r_d_pc <= r_pc;
         if (bus.fd_clear || w_fetch_illegal) begin
            r_d_instr <= 32'h0;
            r_d_valid <= 1'b0;
         end else begin
            r_d_instr <= bus.i_inst_rdata;
            r_d_valid <= 1'b1;
         end
      end
   end

   // The stall counter counts every stalled edge and stops at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (bus.stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bus.F_PC        = r_pc;
   assign bus.i_inst_addr = r_pc;   // IM is asynchronous-read: no extra stage
   assign bus.D_instr     = r_d_instr;
   assign bus.D_PC        = r_d_pc;
   assign bus.D_valid     = r_d_valid;
   assign bus.stall_cnt   = r_stall_cnt;

endmodule
